// File: rtl/cache_dm_wt_if.sv
// Core/memory bus bundle for the direct-mapped write-through cache.
// slave  : view taken by the cache controller.
// master : view taken by the environment (core load/store port + memory).
// Core side   : ren, wen, addr, din, storecntrl, loadcntrl, flush -> cache;
//               cache_rdy, dout, dout_valid, err <- cache.
// Memory side : mem_dout, mem_rdy -> cache;
//               mem_ren, mem_wen, mem_addr, mem_din, mem_wstrb <- cache.
interface cache_dm_wt_if #(
  parameter int ADDR_W = 32,
  parameter int LANES  = 4
);
  localparam int DATA_W = 8 * LANES;

  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [2:0]        storecntrl;
  logic [4:0]        loadcntrl;
  logic              flush;
  logic              cache_rdy;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              err;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_rdy;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [LANES-1:0]  mem_wstrb;

  modport slave (
    input  ren, wen, addr, din, storecntrl, loadcntrl, flush, mem_dout, mem_rdy,
    output cache_rdy, dout, dout_valid, err, mem_ren, mem_wen, mem_addr, mem_din, mem_wstrb
  );

  modport master (
    output ren, wen, addr, din, storecntrl, loadcntrl, flush, mem_dout, mem_rdy,
    input  cache_rdy, dout, dout_valid, err, mem_ren, mem_wen, mem_addr, mem_din, mem_wstrb
  );
endinterface

// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// one-word lines, LANES byte-wide synchronous data arrays, tag/valid storage,
// RISC-V style load formatting, misalignment/illegal-control error and flush.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : cache_dm_wt_if.slave (core request/response + byte-strobed memory)
//   hit_cnt/miss_cnt : 32-bit saturating counters, only when CACHE_STATS_EN
//                      is defined.
// Optional feature macro: CACHE_STATS_EN
module cache_dm_wt #(
  parameter int ADDR_W  = 32,
  parameter int LANES   = 4,
  parameter int INDEX_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  cache_dm_wt_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int DATA_W = 8 * LANES;
  localparam int OFF_W  = $clog2(LANES);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES  = 2 ** INDEX_W;
  localparam int HALVES = (LANES > 1) ? LANES / 2 : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_RD, WR_THRU, DONE} state_t;

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic                r_flush_pend;
  logic                r_dout_valid, r_err, r_mem_ren, r_mem_wen;
  logic [DATA_W-1:0]   r_dout, r_mem_din;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LANES-1:0]    r_mem_wstrb;
  logic                r_hit;
  // captured request and lookup read-out
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                r_is_load;
  logic [4:0]          r_lctl;
  logic [2:0]          r_sctl;
  logic [TAG_W-1:0]    r_tag_rd;
  logic                r_vld_rd;
  logic [TAG_W-1:0]    r_tag_arr [LINES];

  logic                w_rdy, w_accept, w_bad, w_hit, w_fill, w_st_hit;
  logic [INDEX_W-1:0]  w_in_idx, w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [OFF_W-1:0]    w_off;
  logic [DATA_W-1:0]   w_data_rd;

  function automatic logic req_bad(input logic ren, input logic wen, input logic [OFF_W-1:0] off,
                                   input logic [4:0] lc, input logic [2:0] sc);
    logic bad, half, word;
    bad  = ren & wen;
    if (ren) begin
      bad  = bad | !$onehot(lc);
      half = lc[1] | lc[4];
      word = lc[2];
    end else begin
      bad  = bad | !$onehot(sc);
      half = sc[1];
      word = sc[2];
    end
    if (half && off[0]) bad = 1'b1;
    if (word && (off != '0)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] w,
                                                 input logic [OFF_W-1:0] off, input logic [4:0] lc);
    logic [DATA_W-1:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    if (lc[0]) return {{(DATA_W-8){b[7]}}, b};
    if (lc[1]) return {{(DATA_W-16){h[15]}}, h};
    if (lc[3]) return {{(DATA_W-8){1'b0}}, b};
    if (lc[4]) return {{(DATA_W-16){1'b0}}, h};
    return w;
  endfunction

  function automatic logic [LANES-1:0] st_strb(input logic [2:0] sc, input logic [OFF_W-1:0] off);
    if (sc[0]) return LANES'(1) << off;
    if (sc[1]) return LANES'(3) << off;
    return '1;
  endfunction

  function automatic logic [DATA_W-1:0] st_rep(input logic [2:0] sc, input logic [DATA_W-1:0] d);
    if (sc[0]) return {LANES{d[7:0]}};
    if (sc[1]) return {HALVES{d[15:0]}};
    return d;
  endfunction

  // A pending flush blocks acceptance so it lands before the next request.
  assign w_rdy    = !rst && !r_flush_pend && (r_state == IDLE || r_state == DONE);
  assign w_accept = w_rdy && (bus.ren || bus.wen) && !bus.flush;
  assign w_in_idx = bus.addr[OFF_W+INDEX_W-1:OFF_W];
  assign w_bad    = req_bad(bus.ren, bus.wen, bus.addr[OFF_W-1:0], bus.loadcntrl, bus.storecntrl);
  assign w_idx    = r_addr[OFF_W+INDEX_W-1:OFF_W];
  assign w_tag    = r_addr[ADDR_W-1:OFF_W+INDEX_W];
  assign w_off    = r_addr[OFF_W-1:0];
  assign w_hit    = r_vld_rd && (r_tag_rd == w_tag);
  assign w_fill   = !rst && (r_state == MISS_RD) && bus.mem_rdy;
  assign w_st_hit = !rst && (r_state == WR_THRU) && bus.mem_rdy && r_hit;

  // ---- stage 0: capture request, read tag/valid/data at acceptance ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr    <= bus.addr;
      r_din     <= bus.din;
      r_is_load <= bus.ren;
      r_lctl    <= bus.loadcntrl;
      r_sctl    <= bus.storecntrl;
      r_tag_rd  <= r_tag_arr[w_in_idx];
      r_vld_rd  <= r_valid[w_in_idx];
    end
    if (w_fill) r_tag_arr[w_idx] <= w_tag;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] r_lane [LINES];
    logic [7:0] r_rd;
    always_ff @(posedge clk) begin
      if (w_fill)
        r_lane[w_idx] <= bus.mem_dout[8*g +: 8];
      else if (w_st_hit && r_mem_wstrb[g])
        r_lane[w_idx] <= r_mem_din[8*g +: 8];
      if (w_accept) r_rd <= r_lane[w_in_idx];
    end
    assign w_data_rd[8*g +: 8] = r_rd;
  end

  // ---- stage 1..n: lookup, memory transaction, completion ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_hit        <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_mem_wstrb  <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      if (bus.flush && (r_state == LOOKUP || r_state == MISS_RD || r_state == WR_THRU))
        r_flush_pend <= 1'b1;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (bus.flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (w_accept) begin
            if (w_bad) r_err   <= 1'b1;
            else       r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_hit      <= w_hit;
          r_mem_addr <= {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          if (r_is_load) begin
            if (w_hit) begin
              r_dout       <= fmt_load(w_data_rd, w_off, r_lctl);
              r_dout_valid <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_mem_ren <= 1'b1;
              r_state   <= MISS_RD;
            end
          end else begin
            r_mem_wen   <= 1'b1;
            r_mem_din   <= st_rep(r_sctl, r_din);
            r_mem_wstrb <= st_strb(r_sctl, w_off);
            r_state     <= WR_THRU;
          end
        end
        MISS_RD: if (bus.mem_rdy) begin
          r_mem_ren      <= 1'b0;
          r_valid[w_idx] <= 1'b1;
          r_dout         <= fmt_load(bus.mem_dout, w_off, r_lctl);
          r_dout_valid   <= 1'b1;
          r_state        <= DONE;
        end
        WR_THRU: if (bus.mem_rdy) begin
          r_mem_wen <= 1'b0;
          r_state   <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (r_state == LOOKUP) begin
      if (w_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

  assign bus.cache_rdy  = w_rdy;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.err        = r_err;
  assign bus.mem_ren    = r_mem_ren;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;
  assign bus.mem_wstrb  = r_mem_wstrb;
endmodule

// File: tb/tb_cache_dm_wt.sv
// Directed bench for cache_dm_wt: stimulus pushes expected load data and
// expected memory writes into queues; monitors pop and compare when the DUT
// presents dout_valid or completes a memory write.
module tb_cache_dm_wt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_dm_wt_if #(.ADDR_W(32), .LANES(4)) ifc ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  cache_dm_wt #(.ADDR_W(32), .LANES(4), .INDEX_W(10)) dut (
    .clk(clk), .rst(rst), .bus(ifc), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  cache_dm_wt #(.ADDR_W(32), .LANES(4), .INDEX_W(10)) dut (
    .clk(clk), .rst(rst), .bus(ifc));
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dv_cyc = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int ren_cyc = 0;
  int wen_cyc = 0;
  int mem_lat = 1;
  logic [31:0] exp_q [$];
  wr_t         wr_q [$];
  logic [31:0] mem_m [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 32'h0;
  endfunction

  // load-response monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (ifc.err) err_cnt++;
      if (ifc.dout_valid) begin
        dv_cyc = cyc;
        dv_cnt++;
        if (exp_q.size() == 0) chk("dout_unexpected", ifc.dout, 32'hx);
        else begin
          e = exp_q.pop_front();
          chk("dout", ifc.dout, e);
        end
      end
    end
  end

  // memory responder + write monitor
  initial begin
    int busy;
    logic [31:0] w;
    wr_t x;
    busy = 0;
    ifc.mem_rdy  = 1'b0;
    ifc.mem_dout = '0;
    forever begin
      @(negedge clk);
      if (ifc.mem_ren) ren_cyc++;
      if (ifc.mem_wen) wen_cyc++;
      if (ifc.mem_ren || ifc.mem_wen) begin
        busy++;
        ifc.mem_dout = rd_word(ifc.mem_addr);
        ifc.mem_rdy  = (busy == mem_lat);
        if (ifc.mem_rdy && ifc.mem_wen) begin
          if (wr_q.size() == 0) chk("wr_unexpected", ifc.mem_addr, 32'hx);
          else begin
            x = wr_q.pop_front();
            chk("wr_addr", ifc.mem_addr, x.a);
            chk("wr_din", ifc.mem_din, x.d);
            chk("wr_strb", 32'(ifc.mem_wstrb), 32'(x.s));
          end
          w = rd_word(ifc.mem_addr);
          for (int i = 0; i < 4; i++)
            if (ifc.mem_wstrb[i]) w[8*i +: 8] = ifc.mem_din[8*i +: 8];
          mem_m[ifc.mem_addr] = w;
        end
      end else begin
        busy = 0;
        ifc.mem_rdy = 1'b0;
      end
    end
  end

  task automatic req(input bit r, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] sc, input logic [4:0] lc, output int t, output bit ra);
    int n;
    @(negedge clk);
    n = 0;
    while (!ifc.cache_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rdy_timeout_pre", 32'(ifc.cache_rdy), 32'd1);
    ifc.ren = r; ifc.wen = wr; ifc.addr = a; ifc.din = d;
    ifc.storecntrl = sc; ifc.loadcntrl = lc;
    t = cyc;
    @(negedge clk);
    ra = ifc.cache_rdy;
    ifc.ren = 1'b0; ifc.wen = 1'b0;
    n = 0;
    while (!ifc.cache_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("rdy_timeout_post", 32'(ifc.cache_rdy), 32'd1);
    #1;
  endtask

  task automatic load(input string nm, input logic [31:0] a, input logic [4:0] lc,
                      input logic [31:0] expv, input int lat_exp, input int ren_exp);
    int t, r0;
    bit ra;
    r0 = ren_cyc;
    exp_q.push_back(expv);
    req(1'b1, 1'b0, a, 32'h0, 3'b000, lc, t, ra);
    chk({nm, "_rdy_drop"}, 32'(ra), 32'd0);
    chk({nm, "_latency"}, dv_cyc - t, lat_exp);
    chk({nm, "_mem_ren_cycles"}, ren_cyc - r0, ren_exp);
  endtask

  task automatic store(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sc, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] es);
    int t, w0, d0;
    bit ra;
    wr_t x;
    w0 = wen_cyc; d0 = dv_cnt;
    x.a = ea; x.d = ed; x.s = es;
    wr_q.push_back(x);
    req(1'b0, 1'b1, a, d, sc, 5'b00000, t, ra);
    chk({nm, "_no_dout_valid"}, dv_cnt - d0, 0);
    chk({nm, "_mem_wen_cycles"}, wen_cyc - w0, mem_lat);
  endtask

  task automatic bad_req(input string nm, input bit r, input bit wr, input logic [31:0] a,
                         input logic [2:0] sc, input logic [4:0] lc);
    int t, e0, r0, w0, d0;
    bit ra;
    e0 = err_cnt; r0 = ren_cyc; w0 = wen_cyc; d0 = dv_cnt;
    req(r, wr, a, 32'h0, sc, lc, t, ra);
    repeat (2) @(negedge clk);
    #1;
    chk({nm, "_err_pulse"}, err_cnt - e0, 1);
    chk({nm, "_rdy_stays"}, 32'(ra), 32'd1);
    chk({nm, "_no_mem"}, (ren_cyc - r0) + (wen_cyc - w0), 0);
    chk({nm, "_no_dout_valid"}, dv_cnt - d0, 0);
  endtask

  task automatic flush_cycle();
    @(negedge clk);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, d0, e0;
    ifc.ren = 0; ifc.wen = 0; ifc.addr = 0; ifc.din = 0;
    ifc.storecntrl = 0; ifc.loadcntrl = 0; ifc.flush = 0;
    mem_m[32'h40]   = 32'h8899_AABB;
    mem_m[32'h1040] = 32'h1122_3344;

    repeat (3) @(negedge clk);
    chk("rst_cache_rdy", 32'(ifc.cache_rdy), 0);
    chk("rst_dout_valid", 32'(ifc.dout_valid), 0);
    chk("rst_mem_ren", 32'(ifc.mem_ren | ifc.mem_wen), 0);
    chk("rst_dout", ifc.dout, 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(ifc.cache_rdy), 1);

    // miss with mem_rdy on 2nd MISS_RD cycle, then hit
    mem_lat = 2;
    load("lw40_miss", 32'h40, 5'b00100, 32'h8899_AABB, 4, 2);
    load("lw40_hit",  32'h40, 5'b00100, 32'h8899_AABB, 2, 0);
    load("lb43",  32'h43, 5'b00001, 32'hFFFF_FF88, 2, 0);
    load("lbu43", 32'h43, 5'b01000, 32'h0000_0088, 2, 0);
    load("lh42",  32'h42, 5'b00010, 32'hFFFF_8899, 2, 0);
    load("lhu40", 32'h40, 5'b10000, 32'h0000_AABB, 2, 0);

    // stores
    mem_lat = 1;
    store("sb41", 32'h41, 32'h0000_0012, 3'b001, 32'h40, 32'h1212_1212, 4'b0010);
    load("lw40_after_sb", 32'h40, 5'b00100, 32'h8899_12BB, 2, 0);
    store("sh82", 32'h82, 32'h0000_5566, 3'b010, 32'h80, 32'h5566_5566, 4'b1100);
    store("sw80", 32'h80, 32'hDEAD_BEEF, 3'b100, 32'h80, 32'hDEAD_BEEF, 4'b1111);
    load("lw80_miss", 32'h80, 5'b00100, 32'hDEAD_BEEF, 3, 1);

    // errors
    bad_req("lh43_misalign", 1'b1, 1'b0, 32'h43, 3'b000, 5'b00010);
    bad_req("lw42_misalign", 1'b1, 1'b0, 32'h42, 3'b000, 5'b00100);
    bad_req("ren_and_wen",   1'b1, 1'b1, 32'h40, 3'b100, 5'b00100);
    bad_req("lctl_not_1hot", 1'b1, 1'b0, 32'h40, 3'b000, 5'b00011);
    bad_req("sw81_misalign", 1'b0, 1'b1, 32'h81, 3'b100, 5'b00000);

    // flush in IDLE beats a concurrent load
    r0 = ren_cyc; d0 = dv_cnt; e0 = err_cnt;
    @(negedge clk);
    ifc.flush = 1'b1; ifc.ren = 1'b1; ifc.addr = 32'h40; ifc.loadcntrl = 5'b00100;
    @(negedge clk);
    ifc.flush = 1'b0; ifc.ren = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("flush_req_ignored", (ren_cyc - r0) + (dv_cnt - d0) + (err_cnt - e0), 0);
    chk("flush_rdy", 32'(ifc.cache_rdy), 1);
    load("lw40_after_flush", 32'h40, 5'b00100, 32'h8899_12BB, 3, 1);

    // reset in the middle of a miss
    flush_cycle();
    mem_lat = 1000;
    d0 = dv_cnt;
    @(negedge clk);
    ifc.ren = 1'b1; ifc.addr = 32'h40; ifc.loadcntrl = 5'b00100;
    @(negedge clk);
    ifc.ren = 1'b0;
    n = 0;
    while (!ifc.mem_ren && n < 20) begin @(negedge clk); n++; end
    chk("abort_in_miss_rd", 32'(ifc.mem_ren), 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_mem_ren_drop", 32'(ifc.mem_ren), 0);
    chk("abort_rdy_low", 32'(ifc.cache_rdy), 0);
    rst = 1'b0;
    #1;
    chk("abort_rdy_back", 32'(ifc.cache_rdy), 1);
    chk("abort_no_dout_valid", dv_cnt - d0, 0);
    mem_lat = 1;
    load("lw40_after_abort", 32'h40, 5'b00100, 32'h8899_12BB, 3, 1);

    // conflict on the same index
    load("lw1040_conflict", 32'h1040, 5'b00100, 32'h1122_3344, 3, 1);
    load("lw40_evicted",    32'h40,   5'b00100, 32'h8899_12BB, 3, 1);
    load("lw40_hit_again",  32'h40,   5'b00100, 32'h8899_12BB, 2, 0);
`ifdef CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 32'd1);
    chk("miss_cnt", miss_cnt, 32'd3);
`endif

    repeat (2) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
